// File: rtl/logo_overlay_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg: shared display types and constants for the VGA overlay path.
//   mode_t      screen mode encoding presented on the mode output
//   rgb_t       12-bit 4:4:4 pixel colour
//   KEY_RGB_DEF default transparent colour key in logo ROM data
//   H_ACTIVE / V_ACTIVE visible area size; line V_ACTIVE carries the frame tick
// -----------------------------------------------------------------------------
package disp_pkg;

  typedef enum logic [1:0] {
    TITLE    = 2'b00,
    PLAY     = 2'b01,
    GAMEOVER = 2'b10
  } mode_t;

  typedef logic [11:0] rgb_t;

  localparam rgb_t        KEY_RGB_DEF = 12'h000;
  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned V_ACTIVE    = 480;

endpackage

// File: rtl/logo_overlay_ctrl_if.sv
// -----------------------------------------------------------------------------
// logo_overlay_ctrl_if: bundle of the overlay controller's pixel-path signals.
//   x, y, video_on  scan position and visible flag from vga_sync
//   start_btn       debounced start level; game_over 1-cycle pulse from game logic
//   bg_rgb          background colour for (x,y); logo_rgb ROM data (1 cycle late)
//   rom_row/rom_col logo ROM address; rgb_out composited pixel; mode screen mode
// Modports: slave = the controller, master = the surrounding system.
// -----------------------------------------------------------------------------
interface logo_overlay_ctrl_if;
  import disp_pkg::*;

  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       start_btn;
  logic       game_over;
  rgb_t       bg_rgb;
  rgb_t       logo_rgb;
  logic [5:0] rom_row;
  logic [8:0] rom_col;
  rgb_t       rgb_out;
  mode_t      mode;

  modport master (
    output x, y, video_on, start_btn, game_over, bg_rgb, logo_rgb,
    input  rom_row, rom_col, rgb_out, mode
  );

  modport slave (
    input  x, y, video_on, start_btn, game_over, bg_rgb, logo_rgb,
    output rom_row, rom_col, rgb_out, mode
  );

endinterface

// File: rtl/logo_overlay_ctrl_frame_timer.sv
// -----------------------------------------------------------------------------
// frame_timer: frame tick detection and GAMEOVER frame counting.
//   clk, reset    pixel clock, synchronous active-high reset
//   i_x, i_y      scan position
//   i_clear       restart counters (entry into GAMEOVER)
//   i_count       count frame ticks (mode is GAMEOVER)
//   o_frame_tick  high for the pixel x==0, y==V_LINE
//   o_hold_done   hold counter sits at HOLD_FRAMES-1
//   o_blink_on    logo visibility phase
// Macro LOGO_BLINK_EN: when defined, o_blink_on toggles every BLINK_FRAMES
// frames starting visible; otherwise o_blink_on is constantly 1.
// -----------------------------------------------------------------------------
module frame_timer
  import disp_pkg::*;
#(
  parameter int unsigned V_LINE      = V_ACTIVE,
  parameter int unsigned HOLD_FRAMES = 180
`ifdef LOGO_BLINK_EN
  , parameter int unsigned BLINK_FRAMES = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] i_x,
  input  logic [9:0] i_y,
  input  logic       i_clear,
  input  logic       i_count,
  output logic       o_frame_tick,
  output logic       o_hold_done,
  output logic       o_blink_on
);

  localparam int unsigned HoldW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  logic [HoldW-1:0] r_hold_cnt;

  assign o_frame_tick = (i_x == 10'd0) && (i_y == 10'(V_LINE));
  assign o_hold_done  = (r_hold_cnt == HoldW'(HOLD_FRAMES - 1));

  // Saturates at HOLD_FRAMES-1; the mode leaves GAMEOVER on that tick anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt <= '0;
    end else if (i_clear) begin
      r_hold_cnt <= '0;
    end else if (i_count && o_frame_tick && !o_hold_done) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

`ifdef LOGO_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BlinkW-1:0] r_blink_cnt;
  logic              r_blink_on;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (i_clear) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (i_count && o_frame_tick) begin
      if (r_blink_cnt == BlinkW'(BLINK_FRAMES - 1)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign o_blink_on = r_blink_on;
`else
  assign o_blink_on = 1'b1;
`endif

endmodule

// File: rtl/logo_overlay_ctrl.sv
// -----------------------------------------------------------------------------
// logo_overlay_ctrl: screen-mode sequencer and logo/background pixel compositor.
//   clk, reset  pixel clock, synchronous active-high reset
//   bus (slave) x/y/video_on/start_btn/game_over/bg_rgb/logo_rgb in,
//               rom_row/rom_col (combinational), rgb_out (registered), mode out
// Latency x/y -> rgb_out is 2 cycles; stage 1 lines up with the ROM read.
// Mode changes only commit on the frame tick (x==0, y==V_ACTIVE).
// Macro LOGO_BLINK_EN: enables logo blinking in GAMEOVER.
// -----------------------------------------------------------------------------
module logo_overlay_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned LOGO_X      = 136,
  parameter int unsigned LOGO_Y      = 64,
  parameter int unsigned LOGO_W      = 368,
  parameter int unsigned LOGO_H      = 64,
  parameter int unsigned HOLD_FRAMES = 180,
  parameter rgb_t        KEY_RGB     = KEY_RGB_DEF
`ifdef LOGO_BLINK_EN
  , parameter int unsigned BLINK_FRAMES = 32
`endif
) (
  input  logic                clk,
  input  logic                reset,
  logo_overlay_ctrl_if.slave  bus
);

  localparam logic [10:0] XLo = 11'(LOGO_X);
  localparam logic [10:0] XHi = 11'(LOGO_X + LOGO_W - 1);
  localparam logic [10:0] YLo = 11'(LOGO_Y);
  localparam logic [10:0] YHi = 11'(LOGO_Y + LOGO_H - 1);

  // Mode state and request tracking
  mode_t r_mode;
  mode_t r_pend_mode;
  logic  r_pend_valid;
  logic  r_start_btn_q;

  // Pixel pipeline
  logic  r_in_win_d;
  logic  r_video_on_d;
  logic  r_show_logo_d;
  rgb_t  r_bg_rgb_d;
  rgb_t  r_rgb_out;

  logic  w_in_win;
  logic  w_start_rise;
  logic  w_req_valid;
  mode_t w_req_mode;
  mode_t w_mode_next;
  logic  w_show_logo;
  logic  w_frame_tick;
  logic  w_hold_done;
  logic  w_blink_on;
  logic  w_enter_go;

  // Addresses wrap modulo the ROM size; only meaningful inside the window.
  assign bus.rom_row = 6'(bus.y - 10'(LOGO_Y));
  assign bus.rom_col = 9'(bus.x - 10'(LOGO_X));

  assign w_in_win = ({1'b0, bus.x} >= XLo) && ({1'b0, bus.x} <= XHi) &&
                    ({1'b0, bus.y} >= YLo) && ({1'b0, bus.y} <= YHi);

  assign w_start_rise = bus.start_btn & ~r_start_btn_q;

  // Requests valid in the current mode; in PLAY only game_over counts, so it
  // naturally wins over a simultaneous start edge.
  always_comb begin
    w_req_valid = 1'b0;
    w_req_mode  = r_mode;
    unique case (r_mode)
      TITLE: begin
        if (w_start_rise) begin
          w_req_valid = 1'b1;
          w_req_mode  = PLAY;
        end
      end
      PLAY: begin
        if (bus.game_over) begin
          w_req_valid = 1'b1;
          w_req_mode  = GAMEOVER;
        end
      end
      GAMEOVER: begin
        if (w_start_rise) begin
          w_req_valid = 1'b1;
          w_req_mode  = TITLE;
        end
      end
      default: ;
    endcase
  end

  // A request arriving on the tick itself commits immediately.
  always_comb begin
    w_mode_next = r_mode;
    if (w_frame_tick) begin
      if (w_req_valid) begin
        w_mode_next = w_req_mode;
      end else if (r_pend_valid) begin
        w_mode_next = r_pend_mode;
      end else if ((r_mode == GAMEOVER) && w_hold_done) begin
        w_mode_next = TITLE;
      end
    end
  end

  assign w_enter_go = w_frame_tick && (w_mode_next == GAMEOVER) && (r_mode != GAMEOVER);

  always_comb begin
    w_show_logo = 1'b0;
    unique case (r_mode)
      TITLE:    w_show_logo = 1'b1;
      PLAY:     w_show_logo = 1'b0;
      GAMEOVER: w_show_logo = w_blink_on;
      default:  w_show_logo = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode        <= TITLE;
      r_pend_mode   <= TITLE;
      r_pend_valid  <= 1'b0;
      r_start_btn_q <= 1'b0;
    end else begin
      r_start_btn_q <= bus.start_btn;
      r_mode        <= w_mode_next;
      if (w_frame_tick) begin
        r_pend_valid <= 1'b0;
      end else if (w_req_valid) begin
        // Latest request overwrites any earlier one.
        r_pend_valid <= 1'b1;
        r_pend_mode  <= w_req_mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_win_d    <= 1'b0;
      r_video_on_d  <= 1'b0;
      r_show_logo_d <= 1'b0;
      r_bg_rgb_d    <= '0;
      r_rgb_out     <= '0;
    end else begin
      r_in_win_d    <= w_in_win;
      r_video_on_d  <= bus.video_on;
      r_show_logo_d <= w_show_logo;
      r_bg_rgb_d    <= bus.bg_rgb;
      if (!r_video_on_d) begin
        r_rgb_out <= '0;
      end else if (r_show_logo_d && r_in_win_d && (bus.logo_rgb != KEY_RGB)) begin
        r_rgb_out <= bus.logo_rgb;
      end else begin
        r_rgb_out <= r_bg_rgb_d;
      end
    end
  end

  assign bus.rgb_out = r_rgb_out;
  assign bus.mode    = r_mode;

  frame_timer #(
    .V_LINE      (V_ACTIVE),
    .HOLD_FRAMES (HOLD_FRAMES)
`ifdef LOGO_BLINK_EN
    , .BLINK_FRAMES (BLINK_FRAMES)
`endif
  ) u_frame_timer (
    .clk          (clk),
    .reset        (reset),
    .i_x          (bus.x),
    .i_y          (bus.y),
    .i_clear      (w_enter_go),
    .i_count      (r_mode == GAMEOVER),
    .o_frame_tick (w_frame_tick),
    .o_hold_done  (w_hold_done),
    .o_blink_on   (w_blink_on)
  );

endmodule

// File: tb/tb_logo_overlay_ctrl.sv
// -----------------------------------------------------------------------------
// tb_logo_overlay_ctrl: directed + randomized bench for logo_overlay_ctrl.
// The reference model tracks the screen mode, pending request and frames spent
// in GAMEOVER, and predicts each pixel's composited colour two cycles ahead.
// -----------------------------------------------------------------------------
module tb_logo_overlay_ctrl;
  import disp_pkg::*;

  localparam int LX   = 136;
  localparam int LY   = 64;
  localparam int LW   = 368;
  localparam int LH   = 64;
  localparam int HOLD = 180;
`ifdef LOGO_BLINK_EN
  localparam int BLINK = 32;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logo_overlay_ctrl_if bus ();

  logo_overlay_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: 0 TITLE, 1 PLAY, 2 GAMEOVER; pend -1 = none.
  int          m_mode;
  int          m_pend;
  bit          m_prev_start;
  int          m_go_frames;
  logic [11:0] exp_prev;
  logic [11:0] next_logo;

  // ROM / background stimulus controls
  bit          rom_const_en;
  logic [11:0] rom_const;
  bit          bg_rand;
  logic [11:0] bg_const;
  int          salt;
  bit          st_lvl;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] rom_val(int row, int col);
    if (rom_const_en) return rom_const;
    if ((col % 7) == 3) return 12'h000;
    return 12'((row * 131 + col * 29 + salt) & 32'hfff) | 12'h001;
  endfunction

  task automatic model_reset();
    m_mode       = 0;
    m_pend       = -1;
    m_prev_start = 1'b0;
    m_go_frames  = 0;
  endtask

  task automatic do_reset(int px, int py);
    bus.x         = 10'(px);
    bus.y         = 10'(py);
    bus.video_on  = 1'b1;
    bus.start_btn = 1'b0;
    bus.game_over = 1'b0;
    bus.bg_rgb    = 12'($urandom);
    bus.logo_rgb  = 12'($urandom);
    reset         = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_rgb_out", 16'(bus.rgb_out), 16'h0);
    chk("reset_mode", 16'(bus.mode), 16'(TITLE));
    model_reset();
    exp_prev  = 12'h000;
    next_logo = rom_val((py - LY) & 63, (px - LX) & 511);
  endtask

  task automatic step(int px, int py, bit von, bit st, bit go);
    logic [11:0] bg;
    logic [11:0] exp_now;
    bit inw, show, go_vis, tick, rise;
    int req, nm, row, col;

    bg = bg_rand ? 12'($urandom) : bg_const;
    bus.x         = 10'(px);
    bus.y         = 10'(py);
    bus.video_on  = von;
    bus.start_btn = st;
    bus.game_over = go;
    bus.bg_rgb    = bg;
    bus.logo_rgb  = next_logo;  // ROM answer for the previous pixel
    reset         = 1'b0;

    inw = (px >= LX) && (px < LX + LW) && (py >= LY) && (py < LY + LH);
`ifdef LOGO_BLINK_EN
    go_vis = ((m_go_frames / BLINK) % 2) == 0;
`else
    go_vis = 1'b1;
`endif
    show = (m_mode == 0) || ((m_mode == 2) && go_vis);
    row  = (py - LY) & 63;
    col  = (px - LX) & 511;
    next_logo = rom_val(row, col);
    if (!von) exp_now = 12'h000;
    else if (show && inw && (next_logo != 12'h000)) exp_now = next_logo;
    else exp_now = bg;

    tick = (px == 0) && (py == 480);
    rise = st && !m_prev_start;
    req  = -1;
    if (m_mode == 0 && rise) req = 1;
    else if (m_mode == 1 && go) req = 2;
    else if (m_mode == 2 && rise) req = 0;
    if (tick) begin
      if (m_mode == 2) m_go_frames++;
      if (req >= 0) nm = req;
      else if (m_pend >= 0) nm = m_pend;
      else if (m_mode == 2 && m_go_frames == HOLD) nm = 0;
      else nm = m_mode;
      if (nm == 2 && m_mode != 2) m_go_frames = 0;
      m_mode = nm;
      m_pend = -1;
    end else if (req >= 0) begin
      m_pend = req;
    end
    m_prev_start = st;

    @(posedge clk);
    #1;
    chk("rgb_out", 16'(bus.rgb_out), 16'(exp_prev));
    chk("mode", 16'(bus.mode), 16'(m_mode));
    if (inw) begin
      chk("rom_row", 16'(bus.rom_row), 16'(row));
      chk("rom_col", 16'(bus.rom_col), 16'(col));
    end
    exp_prev = exp_now;
  endtask

  // n pixels biased toward the logo window, then the frame-tick pixel.
  task automatic frame(int n, bit st);
    step(LX + int'($urandom_range(0, LW - 1)), LY + int'($urandom_range(0, LH - 1)), 1'b1, st,
         1'b0);
    for (int i = 1; i < n; i++) begin
      step(int'($urandom_range(100, 540)), int'($urandom_range(40, 150)), 1'b1, st, 1'b0);
    end
    step(0, 480, 1'b0, st, 1'b0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.x         = '0;
    bus.y         = '0;
    bus.video_on  = 1'b0;
    bus.start_btn = 1'b0;
    bus.game_over = 1'b0;
    bus.bg_rgb    = '0;
    bus.logo_rgb  = '0;
    rom_const_en  = 1'b1;
    rom_const     = 12'hF00;
    bg_rand       = 1'b0;
    bg_const      = 12'h00F;
    salt          = int'($urandom_range(0, 4095));
    st_lvl        = 1'b0;
    model_reset();
    exp_prev  = '0;
    next_logo = '0;

    do_reset(0, 0);
    do_reset(0, 0);

    // Window edges and blanking in TITLE
    step(136, 64, 1'b1, 1'b0, 1'b0);
    step(135, 64, 1'b1, 1'b0, 1'b0);
    chk("win_pixel_136_64", 16'(bus.rgb_out), 16'hF00);
    step(200, 100, 1'b0, 1'b0, 1'b0);
    chk("outside_135_64", 16'(bus.rgb_out), 16'h00F);
    step(503, 127, 1'b1, 1'b0, 1'b0);
    chk("video_off", 16'(bus.rgb_out), 16'h000);
    step(504, 127, 1'b1, 1'b0, 1'b0);
    step(136, 63, 1'b1, 1'b0, 1'b0);
    step(136, 128, 1'b1, 1'b0, 1'b0);

    // Coarse sweep over a whole frame including blanking and the tick line
    for (int yy = 0; yy < 525; yy += 8) begin
      for (int xx = 0; xx < 800; xx += 40) begin
        step(xx, yy, (xx < 640) && (yy < 480), 1'b0, 1'b0);
      end
    end

    // Transparency key
    rom_const = 12'h000;
    for (int i = 0; i < 6; i++) step(150 + i * 50, 70 + i * 9, 1'b1, 1'b0, 1'b0);

    // Random ROM contents and backgrounds
    rom_const_en = 1'b0;
    bg_rand      = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step(int'($urandom_range(100, 540)), int'($urandom_range(40, 150)),
           ($urandom_range(0, 9) != 0), 1'b0, 1'b0);
    end

    // Start pressed mid-frame: mode waits for the frame tick
    for (int i = 0; i < 10; i++) step(300 + i, 200, 1'b1, 1'b1, 1'b0);
    chk("title_hold_until_tick", 16'(bus.mode), 16'(TITLE));
    for (int i = 0; i < 10; i++) step(200 + i * 20, 300, 1'b1, 1'b1, 1'b0);
    step(0, 480, 1'b0, 1'b1, 1'b0);
    chk("play_after_tick", 16'(bus.mode), 16'(PLAY));
    frame(20, 1'b1);
    frame(20, 1'b1);
    chk("no_retrigger", 16'(bus.mode), 16'(PLAY));

    // game_over and start edge in the same cycle
    step(250, 90, 1'b1, 1'b0, 1'b0);
    step(260, 90, 1'b1, 1'b1, 1'b1);
    frame(5, 1'b1);
    chk("gameover_priority", 16'(bus.mode), 16'(GAMEOVER));

    // GAMEOVER hold timeout (and blink phases when enabled)
    for (int f = 0; f < HOLD - 1; f++) frame(3, 1'b0);
    chk("gameover_before_timeout", 16'(bus.mode), 16'(GAMEOVER));
    frame(3, 1'b0);
    chk("timeout_to_title", 16'(bus.mode), 16'(TITLE));

    // Start edge coincident with the tick commits on that tick
    step(300, 100, 1'b1, 1'b0, 1'b0);
    step(0, 480, 1'b0, 1'b1, 1'b0);
    chk("tick_coincident", 16'(bus.mode), 16'(PLAY));

    // Enter GAMEOVER, then leave via start edge
    step(300, 100, 1'b1, 1'b1, 1'b1);
    frame(4, 1'b0);
    frame(4, 1'b0);
    step(320, 90, 1'b1, 1'b1, 1'b0);
    frame(4, 1'b1);
    chk("start_exits_gameover", 16'(bus.mode), 16'(TITLE));

    // Reset during PLAY
    step(300, 100, 1'b1, 1'b0, 1'b0);
    frame(4, 1'b1);
    chk("play_before_reset", 16'(bus.mode), 16'(PLAY));
    step(299, 100, 1'b1, 1'b1, 1'b0);
    do_reset(300, 100);
    step(301, 100, 1'b1, 1'b0, 1'b0);
    step(302, 100, 1'b1, 1'b0, 1'b0);
    step(303, 100, 1'b1, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) st_lvl = ~st_lvl;
      if ($urandom_range(0, 399) == 0) begin
        do_reset(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
      end else if ($urandom_range(0, 24) == 0) begin
        step(0, 480, 1'b0, st_lvl, ($urandom_range(0, 29) == 0));
      end else begin
        step(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
             ($urandom_range(0, 7) != 0), st_lvl, ($urandom_range(0, 29) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logo_overlay_ctrl.md
Name: logo_overlay_ctrl

Overview:
- Screen-mode controller and pixel compositor for the VGA path.
- Sequences title, play and game-over modes, and generates row/col addresses for the synchronous logo ROM.
- Aligns the ROM's 1-cycle read latency, then muxes logo pixels over the background colour.
- Sits between vga_sync, the game logic, the logo ROM and the VGA rgb register.

Parameters:
LOGO_X, 136, left column of logo window
LOGO_Y, 64, top row of logo window
LOGO_W, 368, window width in pixels (≤512)
LOGO_H, 64, window height in pixels (≤64)
V_ACTIVE, 480, first non-visible line; frame tick line
BLINK_FRAMES, 32, frames per blink half-period in GAMEOVER
HOLD_FRAMES, 180, frames in GAMEOVER before auto-return to TITLE
KEY_RGB, 12'h000, transparent colour key in logo ROM data

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high reset
x  in  10  current pixel column from vga_sync
y  in  10  current pixel row from vga_sync
video_on  in  1  visible-area flag from vga_sync
start_btn  in  1  debounced start button, level
game_over  in  1  1-cycle pulse from game logic
bg_rgb  in  12  background colour for pixel (x,y), same cycle as x/y
logo_rgb  in  12  ROM data, valid 1 cycle after rom_row/rom_col
rom_row  out  6  logo ROM row address
rom_col  out  9  logo ROM column address
rgb_out  out  12  registered composited pixel
mode  out  2  00 TITLE, 01 PLAY, 10 GAMEOVER

Behaviour:
- Reset values:
  - mode=TITLE; rgb_out=0.
  - Frame counters=0; pending request cleared; button edge register=0.
- Addressing (combinational):
  - rom_row = (y−LOGO_Y)[5:0]; rom_col = (x−LOGO_X)[8:0]; modular truncation.
  - Address values are don't-care outside the window.
- Window: in_win = x∈[LOGO_X, LOGO_X+LOGO_W−1] and y∈[LOGO_Y, LOGO_Y+LOGO_H−1]; unsigned compares, no wrap.
- Pipeline, 2-cycle latency from x/y to rgb_out:
  - Stage 1 registers in_win, video_on, bg_rgb and show_logo.
  - Stage 2 registers rgb_out:
    - if !video_on_d: 0;
    - else if show_logo_d && in_win_d && logo_rgb≠KEY_RGB: logo_rgb;
    - else: bg_rgb_d.
- Frame tick: 1-cycle pulse when x==0 && y==V_ACTIVE. All mode changes commit only on a frame tick, so there is no mid-frame tearing.
- Requests:
  - start_rise = start_btn && !start_btn_q.
  - Requests latch into pending_next; the latest request wins.
  - In PLAY, game_over has priority over start_rise in the same cycle.
- FSM (commit at frame tick):
  - TITLE: start_rise → PLAY. show_logo=1.
  - PLAY: game_over → GAMEOVER. show_logo=0. start_rise is ignored.
  - GAMEOVER: start_rise, or hold_cnt reaching HOLD_FRAMES−1 → TITLE. show_logo = blink phase.
- Counters:
  - hold_cnt counts frame ticks in GAMEOVER and clears on entry.
  - blink_cnt counts 0..BLINK_FRAMES−1 and toggles the phase on wrap. Phase=1 (visible) on entry.
- Event coincident with a frame tick: the event commits at that tick.
- Reset mid-frame: output goes to 0 on the next edge. The pipeline refills within 2 cycles.

Optional Feature:
- Macro: LOGO_BLINK_EN.
- Defined: GAMEOVER logo blinks as described above.
- Undefined: GAMEOVER show_logo=1 constantly; blink_cnt is removed; hold timing is unchanged.

Decomposition:
- Package disp_pkg:
  - mode_t enum (TITLE, PLAY, GAMEOVER);
  - rgb_t 12-bit typedef;
  - KEY_RGB default;
  - H_ACTIVE=640 and V_ACTIVE=480 constants.
- One sub-module, frame_timer: holds the frame-tick detect, hold_cnt and blink_cnt, and outputs frame_tick, hold_done and blink_on.

Test Plan:
- Reset, then sweep a full frame in TITLE with logo_rgb=12'hF00 and bg_rgb=12'h00F:
  - pixel (136,64) → rgb_out=F00 two cycles later;
  - pixel (135,64) → 00F;
  - video_on=0 → 000.
- logo_rgb=12'h000 inside the window → bg_rgb passes through (transparency key).
- start_btn held high mid-frame at y=200 → mode stays TITLE until x=0,y=480, then becomes PLAY. Holding the button high for further frames causes no retrigger.
- In PLAY, game_over and start_rise in the same cycle → GAMEOVER at the next frame tick.
- GAMEOVER with LOGO_BLINK_EN:
  - logo visible in frames 0–31, hidden in frames 32–63;
  - after 180 frame ticks, mode=TITLE.
  - Without the macro, the logo is visible in every GAMEOVER frame.
- Assert reset during PLAY at pixel (300,100) → next cycle mode=TITLE and rgb_out=0. Valid output resumes at pixel cycle +2.
